// File: rtl/uart_wb.sv
// uart_wb: Wishbone slave 8N1 UART for the J1 data bus.
// DATA register pushes the TX FIFO on write and pops the RX holding register on read;
// STATUS reports flags and clears the sticky error bits with write-1-to-clear.
// No wait states: there is no ack, and read data appears one cycle after the access.
module uart_wb #(
    parameter logic [15:0] BASE_ADR     = 16'h1000,
    parameter int          CLKS_PER_BIT = 434,
    parameter int          TX_DEPTH     = 8
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [15:0] wb_adr,
    input  logic        wb_stb,
    input  logic        wb_cyc,
    input  logic        wb_we,
    input  logic [15:0] wb_dat_o,
    output logic [15:0] wb_dat_i,
    input  logic        uart_rxd,
    output logic        uart_txd,
    output logic        irq
);

    localparam int          AW       = $clog2(TX_DEPTH);
    localparam logic [15:0] BIT_END  = 16'(CLKS_PER_BIT - 1);
    localparam logic [15:0] HALF_END = 16'(CLKS_PER_BIT / 2 - 1);

    typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_st_t;
    typedef enum logic [2:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP, RX_WAIT_HI} rx_st_t;

    // ---------------- bus decode ----------------
    logic sel, wr_data, wr_stat, rd, rd_data;
    assign sel     = wb_cyc & wb_stb & (wb_adr[15:2] == BASE_ADR[15:2]);
    assign wr_data = sel & wb_we & ~wb_adr[1];
    assign wr_stat = sel & wb_we & wb_adr[1];
    assign rd      = sel & ~wb_we;
    assign rd_data = rd & ~wb_adr[1];

    // adr[0] is a byte lane select the UART ignores; the high data byte is never stored
    logic unused;
    assign unused = ^{wb_adr[0], wb_dat_o[15:8]};

    // ---------------- TX FIFO ----------------
    logic [7:0]  fifo_mem [TX_DEPTH];
    logic [AW:0] wptr, rptr;
    logic        fifo_empty, fifo_full, tx_pop, push_ok;

    assign fifo_empty = (wptr == rptr);
    assign fifo_full  = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
    // a pop frees a slot in the same cycle, so a push to a full FIFO still lands
    assign push_ok    = wr_data & (~fifo_full | tx_pop);

    // FIFO storage: no reset needed, validity is tracked by the pointers
    always_ff @(posedge clk) begin
        if (push_ok) fifo_mem[wptr[AW-1:0]] <= wb_dat_o[7:0];
    end

    // FIFO pointers
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wptr <= '0;
            rptr <= '0;
        end else begin
            if (push_ok) wptr <= wptr + 1'b1;
            if (tx_pop)  rptr <= rptr + 1'b1;
        end
    end

    // ---------------- TX FSM ----------------
    tx_st_t      tx_st;
    logic [15:0] tx_cnt;
    logic [2:0]  tx_bit;
    logic [7:0]  tx_sh;
    logic        tx_tick;

    assign tx_tick = (tx_cnt == BIT_END);
    // pop when idle, or at the end of a stop bit so frames run back to back
    assign tx_pop  = ~fifo_empty & ((tx_st == TX_IDLE) | ((tx_st == TX_STOP) & tx_tick));

    // serialiser: start bit, 8 data bits LSB first, stop bit; txd is registered
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            tx_st    <= TX_IDLE;
            tx_cnt   <= '0;
            tx_bit   <= '0;
            tx_sh    <= '0;
            uart_txd <= 1'b1;
        end else begin
            case (tx_st)
                TX_IDLE: begin
                    tx_cnt <= '0;
                    if (tx_pop) begin
                        tx_sh    <= fifo_mem[rptr[AW-1:0]];
                        tx_st    <= TX_START;
                        uart_txd <= 1'b0;
                    end
                end
                TX_START: begin
                    if (tx_tick) begin
                        tx_cnt   <= '0;
                        tx_bit   <= '0;
                        tx_st    <= TX_DATA;
                        uart_txd <= tx_sh[0];
                    end else tx_cnt <= tx_cnt + 16'd1;
                end
                TX_DATA: begin
                    if (tx_tick) begin
                        tx_cnt <= '0;
                        if (tx_bit == 3'd7) begin
                            tx_st    <= TX_STOP;
                            uart_txd <= 1'b1;
                        end else begin
                            tx_bit   <= tx_bit + 3'd1;
                            tx_sh    <= {1'b0, tx_sh[7:1]};
                            uart_txd <= tx_sh[1];
                        end
                    end else tx_cnt <= tx_cnt + 16'd1;
                end
                default: begin // TX_STOP
                    if (tx_tick) begin
                        tx_cnt <= '0;
                        if (tx_pop) begin
                            tx_sh    <= fifo_mem[rptr[AW-1:0]];
                            tx_st    <= TX_START;
                            uart_txd <= 1'b0;
                        end else tx_st <= TX_IDLE;
                    end else tx_cnt <= tx_cnt + 16'd1;
                end
            endcase
        end
    end

    // ---------------- RX ----------------
    logic        rxd_s1, rxd_s2;
    rx_st_t      rx_st;
    logic [15:0] rx_cnt;
    logic [2:0]  rx_bit;
    logic [7:0]  rx_sh;
    logic        rx_tick, rx_deliver, rx_bad;

    // two-flop synchroniser; idles high so reset does not look like a start bit
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rxd_s1 <= 1'b1;
            rxd_s2 <= 1'b1;
        end else begin
            rxd_s1 <= uart_rxd;
            rxd_s2 <= rxd_s1;
        end
    end

    assign rx_tick    = (rx_cnt == BIT_END);
    assign rx_deliver = (rx_st == RX_STOP) & rx_tick & rxd_s2;
    assign rx_bad     = (rx_st == RX_STOP) & rx_tick & ~rxd_s2;

    // deserialiser: mid-bit sampling, false-start rejection, break wait after a framing error
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rx_st  <= RX_IDLE;
            rx_cnt <= '0;
            rx_bit <= '0;
            rx_sh  <= '0;
        end else begin
            case (rx_st)
                RX_IDLE: begin
                    rx_cnt <= '0;
                    if (!rxd_s2) rx_st <= RX_START;
                end
                RX_START: begin
                    if (rx_cnt == HALF_END) begin
                        rx_cnt <= '0;
                        rx_bit <= '0;
                        rx_st  <= rxd_s2 ? RX_IDLE : RX_DATA;
                    end else rx_cnt <= rx_cnt + 16'd1;
                end
                RX_DATA: begin
                    if (rx_tick) begin
                        rx_cnt <= '0;
                        rx_sh  <= {rxd_s2, rx_sh[7:1]};
                        if (rx_bit == 3'd7) rx_st <= RX_STOP;
                        else                rx_bit <= rx_bit + 3'd1;
                    end else rx_cnt <= rx_cnt + 16'd1;
                end
                RX_STOP: begin
                    if (rx_tick) begin
                        rx_cnt <= '0;
                        rx_st  <= rxd_s2 ? RX_IDLE : RX_WAIT_HI;
                    end else rx_cnt <= rx_cnt + 16'd1;
                end
                default: begin // RX_WAIT_HI: swallow a held break without re-flagging
                    rx_cnt <= '0;
                    if (rxd_s2) rx_st <= RX_IDLE;
                end
            endcase
        end
    end

    // ---------------- holding register, flags, read data ----------------
    logic [7:0]  rx_byte;
    logic        rx_valid, rx_ovr, tx_ovf, rx_ferr, tx_idle;
    logic        rx_load, ovr_set, ovf_set;
    logic [15:0] status;

    // a DATA read in the delivery cycle frees the holding register for the new byte
    assign rx_load = rx_deliver & (~rx_valid | rd_data);
    assign ovr_set = rx_deliver & rx_valid & ~rd_data;
    assign ovf_set = wr_data & fifo_full & ~tx_pop;
    assign tx_idle = fifo_empty & (tx_st == TX_IDLE);
    assign status  = {10'b0, rx_ferr, tx_ovf, rx_ovr, rx_valid, fifo_full, tx_idle};
    assign irq     = rx_valid;

    // RX holding register and sticky flags; a set event beats a same-cycle clear
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rx_byte  <= '0;
            rx_valid <= 1'b0;
            rx_ovr   <= 1'b0;
            tx_ovf   <= 1'b0;
            rx_ferr  <= 1'b0;
        end else begin
            if (rx_load) begin
                rx_byte  <= rx_sh;
                rx_valid <= 1'b1;
            end else if (rd_data) rx_valid <= 1'b0;
            rx_ovr  <= ovr_set | (rx_ovr  & ~(wr_stat & wb_dat_o[3]));
            tx_ovf  <= ovf_set | (tx_ovf  & ~(wr_stat & wb_dat_o[4]));
            rx_ferr <= rx_bad  | (rx_ferr & ~(wr_stat & wb_dat_o[5]));
        end
    end

    // registered read data, zero whenever the previous cycle was not a read
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)    wb_dat_i <= '0;
        else if (rd)     wb_dat_i <= wb_adr[1] ? status : {rx_valid, 7'b0, rx_byte};
        else             wb_dat_i <= '0;
    end

endmodule

// File: tb/tb_uart_wb.sv
// tb_uart_wb: scoreboard bench for uart_wb (CLKS_PER_BIT=8, TX_DEPTH=4).
// TX bytes are queued when written and popped by a serial line monitor;
// RX read values are queued when frames are driven and popped by DATA reads.
module tb_uart_wb;
    localparam int CPB = 8;

    logic        clk = 1'b0;
    logic        reset_n = 1'b1;
    logic [15:0] wb_adr = '0;
    logic        wb_stb = 1'b0, wb_cyc = 1'b0, wb_we = 1'b0;
    logic [15:0] wb_dat_o = '0;
    logic [15:0] wb_dat_i;
    logic        uart_rxd = 1'b1;
    logic        uart_txd, irq;

    int errors = 0, checks = 0, cyc_cnt = 0;
    logic [7:0]  tx_exp[$];
    logic [15:0] rx_exp[$];
    int          fstart[$];
    bit          rst_evt = 1'b0;

    uart_wb #(.BASE_ADR(16'h1000), .CLKS_PER_BIT(CPB), .TX_DEPTH(4)) dut (
        .clk(clk), .reset_n(reset_n),
        .wb_adr(wb_adr), .wb_stb(wb_stb), .wb_cyc(wb_cyc), .wb_we(wb_we),
        .wb_dat_o(wb_dat_o), .wb_dat_i(wb_dat_i),
        .uart_rxd(uart_rxd), .uart_txd(uart_txd), .irq(irq)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc_cnt++;
    always @(negedge reset_n) rst_evt = 1'b1;

    task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    // all bus tasks start 1 ns after a rising edge and use the current cycle
    task automatic bus_rd(input logic [15:0] a, output logic [15:0] d);
        wb_adr = a; wb_we = 1'b0; wb_cyc = 1'b1; wb_stb = 1'b1;
        @(posedge clk); #1;
        d = wb_dat_i;
        wb_cyc = 1'b0; wb_stb = 1'b0;
    endtask

    task automatic bus_wr(input logic [15:0] a, input logic [15:0] d);
        wb_adr = a; wb_dat_o = d; wb_we = 1'b1; wb_cyc = 1'b1; wb_stb = 1'b1;
        @(posedge clk); #1;
        wb_cyc = 1'b0; wb_stb = 1'b0; wb_we = 1'b0;
    endtask

    task automatic rd_chk(input string tag, input logic [15:0] a, input logic [15:0] exp);
        logic [15:0] d;
        bus_rd(a, d);
        chk(tag, d, exp);
    endtask

    task automatic rd_data_chk(input string tag);
        logic [15:0] d, e;
        bus_rd(16'h1000, d);
        e = (rx_exp.size() != 0) ? rx_exp.pop_front() : 16'hffff;
        chk(tag, d, e);
    endtask

    // drive one 8N1 frame; optionally read DATA in the cycle the byte is delivered
    task automatic rx_send(input logic [7:0] b, input logic stop, input bit rd_deliv);
        uart_rxd = 1'b0; tick(CPB);
        for (int i = 0; i < 8; i++) begin uart_rxd = b[i]; tick(CPB); end
        uart_rxd = stop;
        if (rd_deliv) begin
            tick(6);
            rd_data_chk("rx_deliv_rd");
            tick(1);
        end else tick(CPB);
    endtask

    // serial line monitor: decodes each TX frame at mid-bit and scores it
    initial begin : tx_mon
        logic [7:0] b;
        logic       ok;
        forever begin
            @(negedge uart_txd);
            rst_evt = 1'b0;
            fstart.push_back(cyc_cnt);
            repeat (CPB/2) @(posedge clk);
            ok = (uart_txd == 1'b0);
            for (int i = 0; i < 8; i++) begin
                repeat (CPB) @(posedge clk);
                b[i] = uart_txd;
            end
            repeat (CPB) @(posedge clk);
            ok = ok & uart_txd;
            if (!rst_evt) begin
                if (tx_exp.size() == 0) chk("tx_unexpected", {8'h0, b}, 16'hffff);
                else                    chk("tx_byte", {7'b0, ok, b}, {7'b0, 1'b1, tx_exp.pop_front()});
            end
        end
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin : main
        // reset values
        #2 reset_n = 1'b0;
        #1;
        chk("rst_txd", {15'b0, uart_txd}, 16'h0001);
        chk("rst_dat_i", wb_dat_i, 16'h0000);
        chk("rst_irq", {15'b0, irq}, 16'h0000);
        repeat (3) @(posedge clk);
        #1 reset_n = 1'b1;
        tick(2);
        rd_chk("rst_status", 16'h1002, 16'h0001);
        tick(1);
        chk("dat_i_idle", wb_dat_i, 16'h0000);
        rd_chk("rst_data", 16'h1000, 16'h0000);

        // single byte: start bit two cycles after the write, idle at end of stop bit
        tx_exp.push_back(8'hA5);
        bus_wr(16'h1000, 16'h00A5);
        chk("txd_n1", {15'b0, uart_txd}, 16'h0001);
        tick(1);
        chk("txd_start", {15'b0, uart_txd}, 16'h0000);
        tick(79);
        rd_chk("stat_in_stop", 16'h1002, 16'h0000);
        rd_chk("stat_end_stop", 16'h1003, 16'h0001);

        // FIFO fill while busy: four queued, fifth dropped, frames back to back
        tick(10);
        fstart.delete();
        tx_exp.push_back(8'h10);
        bus_wr(16'h1000, 16'h0010);
        tick(3);
        for (int i = 1; i <= 4; i++) tx_exp.push_back(8'(8'h10 + i));
        wb_adr = 16'h1000; wb_we = 1'b1; wb_cyc = 1'b1; wb_stb = 1'b1;
        for (int i = 1; i <= 5; i++) begin
            wb_dat_o = 16'(16'h0010 + i);
            @(posedge clk); #1;
        end
        wb_cyc = 1'b0; wb_stb = 1'b0; wb_we = 1'b0;
        rd_chk("stat_full_ovf", 16'h1002, 16'h0012);
        tick(90);
        rd_chk("stat_draining", 16'h1002, 16'h0010);
        tick(340);
        rd_chk("stat_done_ovf", 16'h1002, 16'h0011);
        bus_wr(16'h1002, 16'h0010);
        rd_chk("stat_ovf_clr", 16'h1002, 16'h0001);
        chk("tx_frames", 16'(fstart.size()), 16'd5);
        for (int i = 1; i < fstart.size(); i++)
            chk("tx_gap", 16'(fstart[i] - fstart[i-1]), 16'd80);
        chk("tx_pending", 16'(tx_exp.size()), 16'd0);
        // outside the decoded window: no push
        bus_wr(16'h1004, 16'h0099);
        tick(20);
        rd_chk("stat_nosel", 16'h1002, 16'h0001);

        // RX byte, irq, pop
        rx_exp.push_back(16'h803C);
        rx_send(8'h3C, 1'b1, 1'b0);
        chk("irq_set", {15'b0, irq}, 16'h0001);
        rd_data_chk("rx_3c");
        chk("irq_clr", {15'b0, irq}, 16'h0000);

        // overrun keeps the old byte
        rx_exp.push_back(16'h8001);
        rx_send(8'h01, 1'b1, 1'b0);
        tick(4);
        rx_send(8'h02, 1'b1, 1'b0);
        rd_chk("stat_ovr", 16'h1002, 16'h000D);
        rd_data_chk("rx_ovr_keep");
        rd_chk("stat_ovr_sticky", 16'h1002, 16'h0009);
        bus_wr(16'h1002, 16'h0008);

        // pop in the delivery cycle: new byte lands, no overrun
        rx_exp.push_back(16'h8001);
        rx_exp.push_back(16'h8002);
        rx_send(8'h01, 1'b1, 1'b0);
        tick(4);
        rx_send(8'h02, 1'b1, 1'b1);
        rd_chk("stat_no_ovr", 16'h1002, 16'h0005);
        rd_data_chk("rx_02");

        // framing error with held break: flagged once
        rx_send(8'hA7, 1'b0, 1'b0);
        tick(20);
        rd_chk("stat_ferr", 16'h1002, 16'h0021);
        bus_wr(16'h1002, 16'h0020);
        tick(30);
        rd_chk("stat_break", 16'h1002, 16'h0001);
        uart_rxd = 1'b1;
        tick(10);
        rx_exp.push_back(16'h8055);
        rx_send(8'h55, 1'b1, 1'b0);
        rd_data_chk("rx_55");

        // short glitch is rejected, receiver still works afterwards
        uart_rxd = 1'b0;
        tick(2);
        uart_rxd = 1'b1;
        tick(30);
        rd_chk("stat_glitch", 16'h1002, 16'h0001);
        chk("irq_glitch", {15'b0, irq}, 16'h0000);
        rx_exp.push_back(16'h805A);
        rx_send(8'h5A, 1'b1, 1'b0);
        rd_data_chk("rx_5a");

        // reset in the middle of TX and RX frames
        bus_wr(16'h1000, 16'h0000);
        uart_rxd = 1'b0;
        tick(20);
        chk("txd_mid_frame", {15'b0, uart_txd}, 16'h0000);
        @(posedge clk); #3;
        reset_n = 1'b0;
        #1;
        chk("txd_async_rst", {15'b0, uart_txd}, 16'h0001);
        chk("dat_i_in_rst", wb_dat_i, 16'h0000);
        uart_rxd = 1'b1;
        repeat (3) @(posedge clk);
        #1 reset_n = 1'b1;
        tick(2);
        rd_chk("rst2_data", 16'h1000, 16'h0000);
        rd_chk("rst2_status", 16'h1002, 16'h0001);
        tick(100);
        chk("txd_after_rst", {15'b0, uart_txd}, 16'h0001);

        chk("rx_pending", 16'(rx_exp.size()), 16'd0);
        chk("tx_pending_end", 16'(tx_exp.size()), 16'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
